// File: rtl/mem_responder_pkg.sv
// Shared constants, executor state encoding and the masked-merge helper
// used by the memory responder slice.
package mem_responder_pkg;

    localparam int MEM_DATA_BITS = 128;
    localparam int MEM_MASK_BITS = 16;
    localparam int MEM_BURST_LEN = 4;

    typedef enum logic [1:0] {
        EXEC_IDLE  = 2'b00,
        EXEC_WAIT  = 2'b01,
        EXEC_BURST = 2'b10
    } exec_state_e;

    // Byte-wise merge of new write data into an existing line under a byte mask.
    function automatic logic [MEM_DATA_BITS-1:0] merge_masked(
        input logic [MEM_DATA_BITS-1:0] old_line,
        input logic [MEM_DATA_BITS-1:0] new_line,
        input logic [MEM_MASK_BITS-1:0] mask
    );
        logic [MEM_DATA_BITS-1:0] res;
        res = old_line;
        for (int i = 0; i < MEM_MASK_BITS; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_line[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_line[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request FIFO: synchronous, power-of-two depth, exposes its
// occupancy so the responder can compute next-cycle ready.
module mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign dout_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    // Entry storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: queues masked writes and 4-beat read bursts in
// order, commits writes to a line store and streams read bursts back after
// a fixed latency with no response backpressure.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS  = 28,
    parameter int STORE_BITS = 10,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    output logic                     mem_req_ready,
    input  logic [ADDR_BITS-1:0]     mem_req_addr,
    input  logic                     mem_req_rw,
    input  logic                     mem_req_data_valid,
    output logic                     mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
    input  logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
    output logic                     mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0] mem_resp_data
);

    localparam int ENTRY_W = ADDR_BITS + 1 + MEM_DATA_BITS + MEM_MASK_BITS;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT_W   = $clog2(LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

    logic [MEM_DATA_BITS-1:0] store_q [0:(1<<STORE_BITS)-1];

    exec_state_e            state_q, state_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [1:0]             beat_q, beat_d;
    logic [STORE_BITS-1:0]  raddr_q, raddr_d;
    logic                   pending_q, pending_d;
    logic                   ready_q, ready_d;
    logic                   resp_valid_q;
    logic [MEM_DATA_BITS-1:0] resp_data_q;

    logic                   accept_rd_s, accept_wr_s, push_s, pop_s;
    logic                   wr_en_s, burst_done_s;
    logic [ENTRY_W-1:0]     push_entry_s, head_s;
    logic [CNT_W-1:0]       fifo_count_s, count_next_s;
    logic                   fifo_full_s, fifo_empty_s;
    logic [ADDR_BITS-1:0]   head_addr_s;
    logic                   head_rw_s;
    logic [MEM_DATA_BITS-1:0] head_data_s;
    logic [MEM_MASK_BITS-1:0] head_mask_s;
    logic [STORE_BITS-1:0]  beat_line_s;
    logic                   unused_addr_hi_s;

    // Acceptance uses only registered ready, so ready can never be raised
    // combinationally by a pop in the same cycle.
    assign accept_rd_s  = mem_req_valid && !mem_req_rw && ready_q && !fifo_full_s;
    assign accept_wr_s  = mem_req_valid && mem_req_rw && mem_req_data_valid && ready_q && !fifo_full_s;
    assign push_s       = accept_rd_s || accept_wr_s;
    assign push_entry_s = {mem_req_addr, mem_req_rw, mem_req_data_bits, mem_req_data_mask};

    assign head_mask_s = head_s[MEM_MASK_BITS-1:0];
    assign head_data_s = head_s[MEM_MASK_BITS +: MEM_DATA_BITS];
    assign head_rw_s   = head_s[MEM_MASK_BITS + MEM_DATA_BITS];
    assign head_addr_s = head_s[MEM_MASK_BITS + MEM_DATA_BITS + 1 +: ADDR_BITS];
    // Upper line-address bits alias onto the store and are intentionally dropped.
    assign unused_addr_hi_s = ^head_addr_s[ADDR_BITS-1:STORE_BITS];

    mem_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .din_i   (push_entry_s),
        .pop_i   (pop_s),
        .dout_o  (head_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Executor next-state: pop in IDLE, count down latency in WAIT, stream beats in BURST.
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        beat_d       = beat_q;
        raddr_d      = raddr_q;
        pop_s        = 1'b0;
        wr_en_s      = 1'b0;
        burst_done_s = 1'b0;
        case (state_q)
            EXEC_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (head_rw_s) begin
                        wr_en_s = 1'b1;
                    end else begin
                        raddr_d = head_addr_s[STORE_BITS-1:0];
                        lat_d   = LAT_LOAD;
                        beat_d  = 2'd0;
                        state_d = (LATENCY == 2) ? EXEC_BURST : EXEC_WAIT;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            EXEC_WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                // Leave one cycle earlier than a literal count-to-one so the
                // registered response lands exactly LATENCY cycles after pop-1.
                if (lat_q <= LAT_W'(2)) begin
                    state_d = EXEC_BURST;
                    beat_d  = 2'd0;
                end else begin
                    state_d = EXEC_WAIT;
                end
            end
            EXEC_BURST: begin
                if (beat_q == 2'(MEM_BURST_LEN - 1)) begin
                    burst_done_s = 1'b1;
                    state_d      = EXEC_IDLE;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            default: begin
                state_d = EXEC_IDLE;
            end
        endcase
    end

    // Read-pending flag and next-cycle ready derived from next occupancy.
    always_comb begin
        if (accept_rd_s) begin
            pending_d = 1'b1;
        end else if (burst_done_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        count_next_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s && !fifo_empty_s);
        ready_d      = (count_next_s < CNT_W'(FIFO_DEPTH)) && !pending_d;
    end

    // Beat address wraps within the aligned 4-line block.
    assign beat_line_s = {raddr_d[STORE_BITS-1:2], raddr_d[1:0] + beat_d};

    // Control state, ready and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EXEC_IDLE;
            lat_q        <= {LAT_W{1'b0}};
            beat_q       <= 2'd0;
            raddr_q      <= {STORE_BITS{1'b0}};
            pending_q    <= 1'b0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= {MEM_DATA_BITS{1'b0}};
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            beat_q       <= beat_d;
            raddr_q      <= raddr_d;
            pending_q    <= pending_d;
            ready_q      <= ready_d;
            resp_valid_q <= (state_d == EXEC_BURST);
            resp_data_q  <= (state_d == EXEC_BURST) ? store_q[beat_line_s] : {MEM_DATA_BITS{1'b0}};
        end
    end

    // Backing store: masked write commit, no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            store_q[head_addr_s[STORE_BITS-1:0]] <=
                merge_masked(store_q[head_addr_s[STORE_BITS-1:0]], head_data_s, head_mask_s);
        end
    end

    assign mem_req_ready      = ready_q;
    assign mem_req_data_ready = ready_q;
    assign mem_resp_valid     = resp_valid_q;
    assign mem_resp_data      = resp_data_q;

endmodule
